// File: rtl/toggle_handshake_rx.sv
// ---------------------------------------------------------------------------
// toggle_handshake_rx
//
// Receiving side of a two-phase (toggle) handshake. The sender flips req_tog
// once per transfer. Each flip is captured, together with req_data, into a
// one-entry buffer that is offered on a valid/ready interface. Once the
// consumer takes the word, ack_tog is set equal to the accepted toggle level,
// which tells the sender it may start the next transfer. Accepted requests
// are counted, and a sticky flag records any toggle that arrives while the
// buffer is still full.
//
// Ports:
//   clk          - single clock, all state changes on its rising edge
//   rst_n        - synchronous active-low reset
//   req_tog      - request toggle level from the sender
//   req_data     - data word accompanying a request
//   ack_tog      - acknowledge toggle returned to the sender
//   out_valid    - buffer holds a word that has not been consumed
//   out_ready    - consumer takes the word when out_valid is also high
//   out_data     - buffered word, stable while out_valid is high
//   event_count  - requests accepted since reset, wraps silently
//   overrun      - sticky flag, sender toggled again before being acked
//   clr_overrun  - synchronous clear of overrun
// ---------------------------------------------------------------------------
module toggle_handshake_rx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_tog,
    input  logic [WIDTH-1:0] req_data,
    output logic             ack_tog,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] event_count,
    output logic             overrun,
    input  logic             clr_overrun
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q,       state_d;
    logic               tog_seen_q,    tog_seen_d;
    logic               ack_tog_q,     ack_tog_d;
    logic               out_valid_q,   out_valid_d;
    logic [WIDTH-1:0]   out_data_q,    out_data_d;
    logic [CNT_W-1:0]   event_count_q, event_count_d;
    logic               overrun_q,     overrun_d;
    logic               pending;
    logic               overrun_set;

    // A request is outstanding whenever the sender's level differs from the
    // last level we accepted.
    assign pending = (req_tog != tog_seen_q);

    always_comb begin
        state_d       = state_q;
        tog_seen_d    = tog_seen_q;
        ack_tog_d     = ack_tog_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        event_count_d = event_count_q;
        overrun_set   = 1'b0;

        case (state_q)
            EMPTY: begin
                if (pending) begin
                    out_data_d    = req_data;
                    tog_seen_d    = req_tog;
                    event_count_d = event_count_q + CNT_W'(1);
                    out_valid_d   = 1'b1;
                    state_d       = FULL;
                end
            end
            FULL: begin
                // A new toggle while still full is a protocol violation; the
                // new word is dropped and tog_seen is left alone so the
                // request is picked up once the buffer drains.
                if (pending) begin
                    overrun_set = 1'b1;
                end
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ack_tog_d   = tog_seen_q;
                    state_d     = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Setting wins over a simultaneous clear so no violation is lost.
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            tog_seen_q    <= 1'b0;
            ack_tog_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            event_count_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tog_seen_q    <= tog_seen_d;
            ack_tog_q     <= ack_tog_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            event_count_q <= event_count_d;
            overrun_q     <= overrun_d;
        end
    end

    assign ack_tog     = ack_tog_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign event_count = event_count_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// ---------------------------------------------------------------------------
// tb_toggle_handshake_rx
//
// Directed bench for toggle_handshake_rx. Inputs change 1 ns after a rising
// edge and outputs are sampled at that same point, well away from the edge.
// Expected values are hand-derived constants or come from the small sender
// model inside the back-to-back sequence.
// ---------------------------------------------------------------------------
module tb_toggle_handshake_rx;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             req_tog;
    logic [WIDTH-1:0] req_data;
    logic             ack_tog;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] event_count;
    logic             overrun;
    logic             clr_overrun;

    int compare_count  = 0;
    int mismatch_count = 0;

    toggle_handshake_rx #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_tog     (req_tog),
        .req_data    (req_data),
        .ack_tog     (ack_tog),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .event_count (event_count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the sequence
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive all sender/consumer inputs at once
    task automatic applyStimulus(input logic tog, input logic [WIDTH-1:0] data,
                                 input logic rdy, input logic clr);
        req_tog     = tog;
        req_data    = data;
        out_ready   = rdy;
        clr_overrun = clr;
    endtask

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Synchronous reset held for n edges; the sender side is reset alongside
    task automatic doReset(input int n, input logic rdy);
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, rdy, 1'b0);
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    logic [WIDTH-1:0] rx_words[$];
    int               rx_cycles[$];
    int               cycle_no;
    logic             tog;
    bit               acked;

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // ---------------- Reset and idle ----------------
        doReset(3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("reset_idle_outputs",
                        {13'd0, ack_tog, out_valid, overrun, event_count, out_data}, 32'd0);
            tick();
        end

        // ---------------- Single transfer ----------------
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        tick();
        checkOutput("single_valid", out_valid, 1);
        checkOutput("single_data", out_data, 8'hA5);
        checkOutput("single_count", event_count, 1);
        checkOutput("single_ack_held", ack_tog, 0);
        tick();
        checkOutput("single_still_valid", out_valid, 1);
        checkOutput("single_ack_still_0", ack_tog, 0);
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("single_consumed", out_valid, 0);
        checkOutput("single_ack", ack_tog, 1);
        checkOutput("single_no_overrun", overrun, 0);

        // ---------------- Back-to-back with a sender model ----------------
        doReset(1, 1'b1);
        tog = 1'b0;
        cycle_no = 0;
        rx_words.delete();
        rx_cycles.delete();
        for (int w = 1; w <= 4; w++) begin
            tog = ~tog;
            applyStimulus(tog, WIDTH'(w), 1'b1, 1'b0);
            acked = 1'b0;
            for (int b = 0; b < 10 && !acked; b++) begin
                tick();
                cycle_no++;
                if (out_valid) begin
                    rx_words.push_back(out_data);
                    rx_cycles.push_back(cycle_no);
                end
                if (ack_tog == tog) acked = 1'b1;
            end
            if (!acked) checkOutput("b2b_ack_timeout", 0, 1);
        end
        tick();
        checkOutput("b2b_word_count", rx_words.size(), 4);
        for (int i = 0; i < rx_words.size() && i < 4; i++) begin
            checkOutput("b2b_word_order", rx_words[i], i + 1);
        end
        for (int i = 1; i < rx_cycles.size(); i++) begin
            checkOutput("b2b_spacing", rx_cycles[i] - rx_cycles[i-1], 2);
        end
        checkOutput("b2b_event_count", event_count, 4);
        checkOutput("b2b_ack_final", ack_tog, 0);
        checkOutput("b2b_overrun", overrun, 0);
        checkOutput("b2b_idle_after", out_valid, 0);

        // ---------------- Overrun ----------------
        doReset(1, 1'b0);
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        tick();
        checkOutput("ovr_first_valid", out_valid, 1);
        checkOutput("ovr_first_data", out_data, 8'h11);
        applyStimulus(1'b0, 8'h22, 1'b0, 1'b0);
        tick();
        checkOutput("ovr_flag_set", overrun, 1);
        checkOutput("ovr_data_kept", out_data, 8'h11);
        checkOutput("ovr_count_kept", event_count, 1);
        // Clear while the violation is still present must not win
        applyStimulus(1'b0, 8'h22, 1'b0, 1'b1);
        tick();
        checkOutput("ovr_set_beats_clear", overrun, 1);
        applyStimulus(1'b0, 8'h22, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h22, 1'b0, 1'b0);
        checkOutput("ovr_first_consumed", out_valid, 0);
        checkOutput("ovr_ack_after_consume", ack_tog, 1);
        checkOutput("ovr_flag_sticky", overrun, 1);
        tick();
        checkOutput("ovr_second_valid", out_valid, 1);
        checkOutput("ovr_second_data", out_data, 8'h22);
        checkOutput("ovr_second_count", event_count, 2);
        checkOutput("ovr_flag_still_set", overrun, 1);
        applyStimulus(1'b0, 8'h22, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h22, 1'b0, 1'b0);
        checkOutput("ovr_cleared", overrun, 0);
        tick();
        checkOutput("ovr_stays_cleared", overrun, 0);

        // ---------------- Counter wrap ----------------
        doReset(1, 1'b1);
        tog = 1'b0;
        for (int n = 1; n <= 257; n++) begin
            tog = ~tog;
            applyStimulus(tog, WIDTH'(n), 1'b1, 1'b0);
            tick();
            if (n == 255) checkOutput("wrap_count_255", event_count, 255);
            if (n == 256) checkOutput("wrap_count_256", event_count, 0);
            if (n == 257) checkOutput("wrap_count_257", event_count, 1);
            tick();
        end
        checkOutput("wrap_no_overrun", overrun, 0);

        // ---------------- Reset mid-operation ----------------
        doReset(1, 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        tick();
        checkOutput("midrst_loaded_data", out_data, 8'h5A);
        checkOutput("midrst_loaded_valid", out_valid, 1);
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h5A, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_count", event_count, 0);
        checkOutput("midrst_ack", ack_tog, 0);
        checkOutput("midrst_data", out_data, 0);
        applyStimulus(1'b0, 8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("midrst_no_stale", {out_valid, event_count}, 0);
        end

        // A high request level straight after reset counts as a new request
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        tick();
        checkOutput("post_rst_capture", {out_valid, out_data}, {1'b1, 8'h3C});
        checkOutput("post_rst_count", event_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
